spi_flash_pp_ctrl: RTL

//  Sequences a byte-level SPI master through a complete W25Q16 page program: WREN (06h), then PP (02h) + 24-bit

---
 rtl/spi_flash_pp_ctrl_pkg.sv | 29 ++
 rtl/spi_flash_pp_ctrl_if.sv | 29 ++
 rtl/spi_flash_pp_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pp_ctrl_pkg.sv
// Shared opcodes, status-bit position and one-hot state encoding for the
// W25Q16 page-program sequencer.
package spi_flash_pp_ctrl_pkg;

  localparam logic [7:0] OP_WREN     = 8'h06;
  localparam logic [7:0] OP_PP       = 8'h02;
  localparam logic [7:0] OP_RDSR     = 8'h05;
  localparam logic [7:0] OP_DUMMY    = 8'h00;
  localparam int         SR_BUSY_BIT = 0;

  typedef enum logic [10:0] {
    ST_IDLE     = 11'b000_0000_0001,
    ST_WREN     = 11'b000_0000_0010,
    ST_GAP1     = 11'b000_0000_0100,
    ST_PP_CMD   = 11'b000_0000_1000,
    ST_ADDR     = 11'b000_0001_0000,
    ST_DFETCH   = 11'b000_0010_0000,
    ST_DSEND    = 11'b000_0100_0000,
    ST_GAP2     = 11'b000_1000_0000,
    ST_RDSR_CMD = 11'b001_0000_0000,
    ST_POLL     = 11'b010_0000_0000,
    ST_FIN      = 11'b100_0000_0000
  } state_e;

  function automatic logic len_ok(input logic [8:0] len);
    return (len != 9'd0) && (len <= 9'd256);
  endfunction

endpackage

// File: rtl/spi_flash_pp_ctrl_if.sv
// Request, write-data, byte-engine and status signals of the page-program
// controller. slave = controller side, master = user/engine side.
interface spi_flash_pp_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [8:0]  req_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        eng_start;
  logic [7:0]  eng_byte;
  logic        eng_hold_cs;
  logic        eng_done;
  logic [7:0]  eng_rxbyte;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  req_valid, req_addr, req_len, wr_data, wr_valid, eng_done, eng_rxbyte,
    output req_ready, wr_ready, eng_start, eng_byte, eng_hold_cs, busy, done, err
  );

  modport master (
    output req_valid, req_addr, req_len, wr_data, wr_valid, eng_done, eng_rxbyte,
    input  req_ready, wr_ready, eng_start, eng_byte, eng_hold_cs, busy, done, err
  );
endinterface

// File: rtl/spi_flash_pp_ctrl.sv
// Sequences WREN, PP+address+data and RDSR polling through a byte-level SPI
// engine; owns opcodes, CS framing and inter-frame gaps.
module spi_flash_pp_ctrl
  import spi_flash_pp_ctrl_pkg::*;
#(
  parameter logic [7:0]  CS_GAP_CYC = 8'd4,
  parameter logic [15:0] POLL_MAX   = 16'd5000
) (
  input logic                clk,
  input logic                rst_n,
  spi_flash_pp_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic        sent_q, sent_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] poll_q, poll_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        tmo_q, tmo_d;
  logic        err_q, err_d;

  logic        byte_st, byte_fin, eng_start, hold, req_ready, wr_ready;
  logic [7:0]  eng_byte;

  // sent_q marks a byte in flight: start fires once on entry, done is only
  // honoured while a byte is outstanding.
  assign byte_st   = state_q inside {ST_WREN, ST_PP_CMD, ST_ADDR, ST_DSEND, ST_RDSR_CMD, ST_POLL};
  assign eng_start = byte_st && !sent_q;
  assign byte_fin  = byte_st && sent_q && bus.eng_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sent_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      poll_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      data_q  <= data_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sent_d    = (sent_q || eng_start) && !byte_fin;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    poll_d    = poll_q;
    data_d    = data_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    eng_byte  = 8'h00;
    hold      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          len_d  = bus.req_len;
          cnt_d  = '0;
          poll_d = '0;
          last_d = 1'b0;
          tmo_d  = 1'b0;
          if (len_ok(bus.req_len)) state_d = ST_WREN;
          else                     err_d   = 1'b1;
        end
      end
      ST_WREN: begin
        eng_byte = OP_WREN;
        if (byte_fin) begin
          state_d = ST_GAP1;
          gap_d   = '0;
        end
      end
      ST_GAP1: begin
        if (gap_q == CS_GAP_CYC - 8'd1) state_d = ST_PP_CMD;
        else                            gap_d   = gap_q + 8'd1;
      end
      ST_PP_CMD: begin
        eng_byte = OP_PP;
        hold     = 1'b1;
        if (byte_fin) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
        end
      end
      ST_ADDR: begin
        hold = 1'b1;
        case (cnt_q[1:0])
          2'd0:    eng_byte = addr_q[23:16];
          2'd1:    eng_byte = addr_q[15:8];
          default: eng_byte = addr_q[7:0];
        endcase
        if (byte_fin) begin
          if (cnt_q == 9'd2) begin
            state_d = ST_DFETCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      ST_DFETCH: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          data_d  = bus.wr_data;
          state_d = ST_DSEND;
        end
      end
      ST_DSEND: begin
        eng_byte = data_q;
        hold     = (cnt_q != len_q - 9'd1);
        if (byte_fin) begin
          if (!hold) begin
            state_d = ST_GAP2;
            gap_d   = '0;
          end else begin
            state_d = ST_DFETCH;
            cnt_d   = cnt_q + 9'd1;
          end
        end
      end
      ST_GAP2: begin
        if (gap_q == CS_GAP_CYC - 8'd1) state_d = ST_RDSR_CMD;
        else                            gap_d   = gap_q + 8'd1;
      end
      ST_RDSR_CMD: begin
        eng_byte = OP_RDSR;
        hold     = 1'b1;
        if (byte_fin) begin
          state_d = ST_POLL;
          poll_d  = '0;
          last_d  = 1'b0;
        end
      end
      ST_POLL: begin
        // last_q: the CS-releasing byte after BUSY clears or the poll budget runs out
        eng_byte = OP_DUMMY;
        hold     = !last_q;
        if (byte_fin) begin
          if (last_q) begin
            state_d = tmo_q ? ST_IDLE : ST_FIN;
            err_d   = tmo_q;
          end else if (!bus.eng_rxbyte[SR_BUSY_BIT]) begin
            last_d = 1'b1;
          end else if (poll_q == POLL_MAX - 16'd1) begin
            last_d = 1'b1;
            tmo_d  = 1'b1;
          end else begin
            poll_d = poll_q + 16'd1;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready   = req_ready;
  assign bus.wr_ready    = wr_ready;
  assign bus.eng_start   = eng_start;
  assign bus.eng_byte    = eng_byte;
  assign bus.eng_hold_cs = hold;
  assign bus.busy        = !(state_q inside {ST_IDLE, ST_FIN});
  assign bus.done        = (state_q == ST_FIN);
  assign bus.err         = err_q;

endmodule
